// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle for the hazard stall unit: EX/MEM/ID hazard sources in,
// stall/flush controls and performance counters out.
interface hazard_stall_unit_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 ID_EX_MemRead;
    logic                 ID_EX_RegWrite;
    logic [4:0]           ID_EX_RegisterRd;
    logic                 EX_MEM_MemRead;
    logic [4:0]           EX_MEM_RegisterRd;
    logic [4:0]           IF_ID_RegisterRs;
    logic [4:0]           IF_ID_RegisterRt;
    logic                 beq;
    logic                 bne;
    logic                 jump;
    logic                 branch_taken;
    logic                 PCWrite;
    logic                 IF_ID_Write;
    logic                 ID_EX_Bubble;
    logic                 IF_ID_Flush;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] flush_count;

    modport master (
        output ID_EX_MemRead, ID_EX_RegWrite, ID_EX_RegisterRd,
        output EX_MEM_MemRead, EX_MEM_RegisterRd,
        output IF_ID_RegisterRs, IF_ID_RegisterRt,
        output beq, bne, jump, branch_taken,
        input  PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush,
        input  stall_cycles, flush_count
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_RegWrite, ID_EX_RegisterRd,
        input  EX_MEM_MemRead, EX_MEM_RegisterRd,
        input  IF_ID_RegisterRs, IF_ID_RegisterRt,
        input  beq, bne, jump, branch_taken,
        output PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush,
        output stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// ID-stage stall/flush controller: freezes PC and IF/ID with ID/EX bubbles on
// load-use and branch-operand hazards, flushes IF/ID on taken branches/jumps.
module hazard_stall_unit #(
    parameter int CNT_WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    hazard_stall_unit_if.slave hz
);
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t               state_r;
    logic [1:0]           remaining_r;
    logic [CNT_WIDTH-1:0] stall_cycles_r;
    logic [CNT_WIDTH-1:0] flush_count_r;

    logic       branch_s;
    logic       match_ex_s;
    logic       match_mem_s;
    logic [1:0] need_s;
    logic       stall_s;
    logic       flush_s;

    // Hazard classification: required stall count from the current ID/EX/MEM contents.
    always_comb begin
        branch_s    = hz.beq | hz.bne;
        match_ex_s  = (hz.ID_EX_RegisterRd != 5'd0) &&
                      ((hz.ID_EX_RegisterRd == hz.IF_ID_RegisterRs) ||
                       (hz.ID_EX_RegisterRd == hz.IF_ID_RegisterRt));
        match_mem_s = (hz.EX_MEM_RegisterRd != 5'd0) &&
                      ((hz.EX_MEM_RegisterRd == hz.IF_ID_RegisterRs) ||
                       (hz.EX_MEM_RegisterRd == hz.IF_ID_RegisterRt));
        need_s = 2'd0;
        // Rules ordered by cost so the largest stall count wins.
        if (branch_s && hz.ID_EX_MemRead && match_ex_s) begin
            need_s = 2'd2;
        end else if (hz.ID_EX_MemRead && match_ex_s) begin
            need_s = 2'd1;
        end else if (branch_s && hz.ID_EX_RegWrite && !hz.ID_EX_MemRead && match_ex_s) begin
            need_s = 2'd1;
        end else if (branch_s && hz.EX_MEM_MemRead && match_mem_s) begin
            need_s = 2'd1;
        end else begin
            need_s = 2'd0;
        end
    end

    // Stall and flush decisions; reset forces the pipeline to run freely.
    always_comb begin
        stall_s = 1'b0;
        flush_s = 1'b0;
        if (reset) begin
            stall_s = 1'b0;
            flush_s = 1'b0;
        end else begin
            case (state_r)
                ST_RUN:   stall_s = (need_s != 2'd0);
                ST_STALL: stall_s = 1'b1;
                default:  stall_s = 1'b0;
            endcase
            // A branch cannot resolve while its operands are pending, so stall wins.
            if (stall_s) begin
                flush_s = 1'b0;
            end else begin
                flush_s = hz.jump | (branch_s & hz.branch_taken);
            end
        end
    end

    // Multi-cycle stall sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_RUN;
            remaining_r <= 2'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (need_s == 2'd2) begin
                        state_r     <= ST_STALL;
                        remaining_r <= 2'd1;
                    end else begin
                        state_r     <= ST_RUN;
                        remaining_r <= 2'd0;
                    end
                end
                ST_STALL: begin
                    if (remaining_r <= 2'd1) begin
                        state_r     <= ST_RUN;
                        remaining_r <= 2'd0;
                    end else begin
                        state_r     <= ST_STALL;
                        remaining_r <= remaining_r - 2'd1;
                    end
                end
                default: begin
                    state_r     <= ST_RUN;
                    remaining_r <= 2'd0;
                end
            endcase
        end
    end

    // Wrapping performance counters, updated on the edge that ends the event cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_r <= '0;
            flush_count_r  <= '0;
        end else begin
            if (stall_s) begin
                stall_cycles_r <= stall_cycles_r + CNT_WIDTH'(1);
            end
            if (flush_s) begin
                flush_count_r <= flush_count_r + CNT_WIDTH'(1);
            end
        end
    end

    assign hz.PCWrite      = ~stall_s;
    assign hz.IF_ID_Write  = ~stall_s;
    assign hz.ID_EX_Bubble = stall_s;
    assign hz.IF_ID_Flush  = flush_s;
    assign hz.stall_cycles = stall_cycles_r;
    assign hz.flush_count  = flush_count_r;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with 4-bit counters so wrap is reachable.
module tb_hazard_stall_unit;
    localparam int CW = 4;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    hazard_stall_unit_if #(.CNT_WIDTH(CW)) hif ();

    hazard_stall_unit #(.CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif.slave)
    );

    always #5 clk = ~clk;

    task automatic clear_in();
        hif.ID_EX_MemRead     = 1'b0;
        hif.ID_EX_RegWrite    = 1'b0;
        hif.ID_EX_RegisterRd  = 5'd0;
        hif.EX_MEM_MemRead    = 1'b0;
        hif.EX_MEM_RegisterRd = 5'd0;
        hif.IF_ID_RegisterRs  = 5'd0;
        hif.IF_ID_RegisterRt  = 5'd0;
        hif.beq               = 1'b0;
        hif.bne               = 1'b0;
        hif.jump              = 1'b0;
        hif.branch_taken      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic st, input logic fl);
        #1;
        tests_run++;
        assert (hif.PCWrite === ~st) else begin
            tests_failed++;
            $error("FAIL %s PCWrite observed %b expected %b", tag, hif.PCWrite, ~st);
        end
        tests_run++;
        assert (hif.IF_ID_Write === ~st) else begin
            tests_failed++;
            $error("FAIL %s IF_ID_Write observed %b expected %b", tag, hif.IF_ID_Write, ~st);
        end
        tests_run++;
        assert (hif.ID_EX_Bubble === st) else begin
            tests_failed++;
            $error("FAIL %s ID_EX_Bubble observed %b expected %b", tag, hif.ID_EX_Bubble, st);
        end
        tests_run++;
        assert (hif.IF_ID_Flush === fl) else begin
            tests_failed++;
            $error("FAIL %s IF_ID_Flush observed %b expected %b", tag, hif.IF_ID_Flush, fl);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [CW-1:0] sc, input logic [CW-1:0] fc);
        tests_run++;
        assert (hif.stall_cycles === sc) else begin
            tests_failed++;
            $error("FAIL %s stall_cycles observed %0d expected %0d", tag, hif.stall_cycles, sc);
        end
        tests_run++;
        assert (hif.flush_count === fc) else begin
            tests_failed++;
            $error("FAIL %s flush_count observed %0d expected %0d", tag, hif.flush_count, fc);
        end
    endtask

    initial begin
        clk          = 1'b0;
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        clear_in();

        // Outputs forced during reset even with a hazard and a jump present.
        hif.ID_EX_MemRead    = 1'b1;
        hif.ID_EX_RegisterRd = 5'd2;
        hif.IF_ID_RegisterRs = 5'd2;
        hif.jump             = 1'b1;
        chk_out("reset_outputs", 1'b0, 1'b0);
        tick();
        chk_cnt("reset_counters", 4'd0, 4'd0);
        reset = 1'b0;
        clear_in();
        chk_out("idle", 1'b0, 1'b0);

        // Load-use: lw $2 in EX, add with Rs=2 in ID.
        hif.ID_EX_MemRead    = 1'b1;
        hif.ID_EX_RegWrite   = 1'b1;
        hif.ID_EX_RegisterRd = 5'd2;
        hif.IF_ID_RegisterRs = 5'd2;
        chk_out("loaduse_stall", 1'b1, 1'b0);
        tick();
        chk_cnt("loaduse_cnt", 4'd1, 4'd0);
        clear_in();
        hif.EX_MEM_MemRead    = 1'b1;
        hif.EX_MEM_RegisterRd = 5'd2;
        hif.IF_ID_RegisterRs  = 5'd2;
        chk_out("loaduse_release", 1'b0, 1'b0);
        tick();
        chk_cnt("loaduse_cnt_hold", 4'd1, 4'd0);

        // Load then branch: two stalls, the second independent of inputs.
        clear_in();
        hif.ID_EX_MemRead    = 1'b1;
        hif.ID_EX_RegWrite   = 1'b1;
        hif.ID_EX_RegisterRd = 5'd3;
        hif.beq              = 1'b1;
        hif.IF_ID_RegisterRt = 5'd3;
        chk_out("ldbr_stall1", 1'b1, 1'b0);
        tick();
        clear_in();
        chk_out("ldbr_stall2", 1'b1, 1'b0);
        tick();
        chk_cnt("ldbr_cnt", 4'd3, 4'd0);
        hif.beq              = 1'b1;
        hif.IF_ID_RegisterRt = 5'd3;
        hif.branch_taken     = 1'b1;
        chk_out("ldbr_flush", 1'b0, 1'b1);
        tick();
        chk_cnt("ldbr_flush_cnt", 4'd3, 4'd1);
        clear_in();
        chk_out("ldbr_after", 1'b0, 1'b0);

        // Producer writing $0 never stalls.
        hif.ID_EX_MemRead    = 1'b1;
        hif.ID_EX_RegWrite   = 1'b1;
        hif.ID_EX_RegisterRd = 5'd0;
        hif.IF_ID_RegisterRs = 5'd0;
        chk_out("reg0_nostall", 1'b0, 1'b0);
        tick();

        // ALU producer feeding a branch: exactly one stall.
        clear_in();
        hif.ID_EX_RegWrite   = 1'b1;
        hif.ID_EX_RegisterRd = 5'd5;
        hif.bne              = 1'b1;
        hif.IF_ID_RegisterRs = 5'd5;
        chk_out("alubr_stall", 1'b1, 1'b0);
        tick();
        hif.ID_EX_RegWrite    = 1'b0;
        hif.ID_EX_RegisterRd  = 5'd0;
        hif.EX_MEM_RegisterRd = 5'd5;
        chk_out("alubr_release", 1'b0, 1'b0);
        tick();
        chk_cnt("alubr_cnt", 4'd4, 4'd1);

        // ALU producer feeding a non-branch: forwarding handles it.
        clear_in();
        hif.ID_EX_RegWrite   = 1'b1;
        hif.ID_EX_RegisterRd = 5'd5;
        hif.IF_ID_RegisterRs = 5'd5;
        chk_out("alu_nobranch", 1'b0, 1'b0);
        tick();

        // Load in MEM feeding a branch: one stall, then RUN again.
        clear_in();
        hif.EX_MEM_MemRead    = 1'b1;
        hif.EX_MEM_RegisterRd = 5'd7;
        hif.beq               = 1'b1;
        hif.IF_ID_RegisterRt  = 5'd7;
        chk_out("memld_br_stall", 1'b1, 1'b0);
        tick();
        clear_in();
        chk_out("memld_br_release", 1'b0, 1'b0);
        tick();
        chk_cnt("memld_br_cnt", 4'd5, 4'd1);

        // Jump during a hazard: stall only, then flush on the clear cycle.
        hif.ID_EX_MemRead    = 1'b1;
        hif.ID_EX_RegisterRd = 5'd4;
        hif.IF_ID_RegisterRs = 5'd4;
        hif.jump             = 1'b1;
        chk_out("jump_hazard", 1'b1, 1'b0);
        tick();
        clear_in();
        hif.jump = 1'b1;
        chk_out("jump_flush", 1'b0, 1'b1);
        tick();
        chk_cnt("jump_cnt", 4'd6, 4'd2);

        // Reset during the second load->branch stall.
        clear_in();
        hif.ID_EX_MemRead    = 1'b1;
        hif.ID_EX_RegisterRd = 5'd3;
        hif.beq              = 1'b1;
        hif.IF_ID_RegisterRt = 5'd3;
        chk_out("rst_ldbr_stall1", 1'b1, 1'b0);
        tick();
        chk_cnt("rst_ldbr_cnt", 4'd7, 4'd2);
        clear_in();
        hif.jump = 1'b1;
        reset    = 1'b1;
        chk_out("rst_midstall", 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        clear_in();
        chk_out("rst_run_after", 1'b0, 1'b0);
        chk_cnt("rst_cnt_cleared", 4'd0, 4'd0);

        // Counter wrap: 16 consecutive load-use stall cycles.
        hif.ID_EX_MemRead    = 1'b1;
        hif.ID_EX_RegisterRd = 5'd9;
        hif.IF_ID_RegisterRt = 5'd9;
        chk_out("wrap_stall", 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        chk_cnt("wrap_at_15", 4'd15, 4'd0);
        tick();
        chk_cnt("wrap_to_0", 4'd0, 4'd0);
        clear_in();
        chk_out("wrap_done", 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Stall/flush controller for the 5-stage MIPS pipeline; the stalling counterpart of the forwarding unit, which only covers hazards forwarding can resolve. It sits beside the ID stage. It freezes PC and IF/ID and injects ID/EX bubbles for load-use and branch-operand hazards. It flushes IF/ID on taken branches and jumps, and keeps stall/flush performance counters.

## Interface
- CNT_WIDTH, 32, width of the performance counters
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_RegWrite  in  1  instruction in EX writes a register
- ID_EX_RegisterRd  in  5  destination of the EX instruction (post-RegDst mux)
- EX_MEM_MemRead  in  1  instruction in MEM is a load
- EX_MEM_RegisterRd  in  5  destination of the MEM instruction
- IF_ID_RegisterRs, IF_ID_RegisterRt  in  5 each  source registers of the ID instruction
- beq, bne, jump  in  1 each  decoded in ID
- branch_taken  in  1  ID comparator result, valid only when beq|bne
- PCWrite  out  1  0 holds the PC
- IF_ID_Write  out  1  0 holds the IF/ID register
- ID_EX_Bubble  out  1  1 zeroes ID/EX control signals
- IF_ID_Flush  out  1  1 clears IF/ID to a nop
- stall_cycles  out  CNT_WIDTH  count of cycles with stall asserted, wraps
- flush_count  out  CNT_WIDTH  count of flushes, wraps

## Operation
- Internal signal `stall` drives PCWrite=!stall, IF_ID_Write=!stall, ID_EX_Bubble=stall.
- Register 0 never causes a hazard. A match means the producer dest is nonzero and equals IF_ID_RegisterRs or IF_ID_RegisterRt.
- Hazard detection in RUN state gives a required stall count N:
  - Load-use: ID_EX_MemRead and match (any ID instruction). N=1.
  - Branch (beq|bne) with an ALU producer in EX: ID_EX_RegWrite and !ID_EX_MemRead and match. N=1. Forwarding then supplies the operand from EX/MEM.
  - Branch with a load in EX: ID_EX_MemRead and match. N=2. This overrides the load-use rule.
  - Branch with a load in MEM: EX_MEM_MemRead and match. N=1.
  - When several rules fire, the largest N applies.
- The register file writes in the first half-cycle, so MEM/WB producers never stall.
- FSM states are RUN, STALL; a 2-bit `remaining` counter is held alongside.
  - RUN, hazard with N: stall=1 this cycle. If N=2, set remaining=1 and go to STALL; otherwise stay in RUN.
  - RUN, no hazard: stall=0.
  - STALL: stall=1 regardless of inputs. Decrement remaining; at 0 return to RUN.
  - On return to RUN, hazards are re-evaluated from the current inputs. No state is carried over.
- Flush: IF_ID_Flush = !stall and (jump or ((beq|bne) and branch_taken)). Stall has priority, because a branch cannot resolve while its operands are pending.
- Counters increment on each cycle where the event is asserted. They wrap from 2^CNT_WIDTH−1 to 0.

## Timing
- Stall and flush outputs are combinational from state and inputs, for same-cycle effect. The FSM, remaining and the counters are registered.
- While reset=1, outputs are forced to PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0.
- At the reset edge: state=RUN, remaining=0, stall_cycles=0, flush_count=0.
- Reset asserted mid-STALL aborts the stall at that edge; the next cycle is RUN.
- Load-use costs 1 bubble. Load→branch costs 2 consecutive bubbles. ALU→branch costs 1. Taken branch or jump costs 1 flushed slot.
- A counter increment lands on the edge ending the event cycle, so it is visible the next cycle.
- In a cycle with both a hazard and jump, only stall is asserted. The flush occurs on the first non-stalled cycle.

## Test plan
- Load-use hazard: lw $2 in EX (ID_EX_MemRead=1, Rd=2); add in ID with Rs=2. Required: exactly 1 cycle with PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1; stall_cycles 0→1.
- Load then branch: lw $3 in EX; beq in ID with Rt=3. Required: 2 stall cycles, the second in STALL state independent of inputs; stall_cycles=2; then with branch_taken=1, IF_ID_Flush=1 for 1 cycle and flush_count=1.
- Register-zero and ALU-producer cases:
  - Producer dest 0: lw $0 in EX, Rs=0 in ID gives no stall.
  - ALU→branch: add $5 in EX, bne in ID with Rs=5 gives exactly 1 stall.
  - ALU→non-branch: add $5 in EX, add in ID with Rs=5 gives 0 stalls.
- Jump arriving with a concurrent hazard: jump=1 in a hazard cycle gives Flush=0 that cycle and Flush=1 on the next clear cycle.
- Reset mid-STALL: assert reset during the second load→branch stall. Required: outputs at the reset values immediately, the next cycle in RUN, both counters 0.
- Counter wrap: with CNT_WIDTH=4, 16 load-use stalls. Required: stall_cycles wraps 15→0.
